ppm_symbol_feeder: RTL and testbench

Upstream feeder for the PPM modulator. Accepts bytes over a valid/ready interface and buffers them in a small FIFO. Each byte is split into four 2-bit PPM symbols, and every symbol is handed to the modulator as a `ppm_code` value plus a one-cycle `ppm_strobe`. The next symbol is issued only after the modulator returns `ppm_done`, so the modulator never needs its own buffering.

---
 rtl/ppm_symbol_feeder_if.sv | 15 +
 rtl/ppm_symbol_feeder.sv | 100 ++++++++++
 tb/tb_ppm_symbol_feeder.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppm_symbol_feeder_if.sv
// Byte stream into the feeder and the symbol handshake out to the PPM modulator.
interface ppm_symbol_feeder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] ppm_code;
  logic       ppm_strobe;
  logic       ppm_done;

  // master: byte source plus modulator; slave: the feeder itself
  modport master (output tx_data, tx_valid, ppm_done,
                  input  tx_ready, ppm_code, ppm_strobe);
  modport slave  (input  tx_data, tx_valid, ppm_done,
                  output tx_ready, ppm_code, ppm_strobe);
endinterface

// File: rtl/ppm_symbol_feeder.sv
// Byte FIFO feeding the PPM modulator one 2-bit symbol at a time,
// issuing each symbol only after the modulator reports the previous slot done.
module ppm_symbol_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  ppm_symbol_feeder_if.slave          bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    shreg;
  logic [1:0]    remaining;
  logic [1:0]    code_q;
  logic          strobe_q;

  logic       full, empty, push, pop, done_ok, sym_next;
  logic [7:0] head, head_rest, sh_rest;
  logic [1:0] head_sym, sh_sym;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.tx_valid && bus.tx_ready;

  // A done coinciding with our own strobe would be a zero-length slot; drop it.
  assign done_ok  = (state == S_WAIT) && bus.ppm_done && !strobe_q;
  assign sym_next = done_ok && (remaining != 2'd0);
  assign pop      = !empty && ((state == S_IDLE) || (done_ok && remaining == 2'd0));

  // The shift register keeps the next symbol at the end it is emitted from.
  assign head      = mem[rd_ptr];
  assign head_sym  = MSB_FIRST ? head[7:6] : head[1:0];
  assign head_rest = MSB_FIRST ? {head[5:0], 2'b00} : {2'b00, head[7:2]};
  assign sh_sym    = MSB_FIRST ? shreg[7:6] : shreg[1:0];
  assign sh_rest   = MSB_FIRST ? {shreg[5:0], 2'b00} : {2'b00, shreg[7:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      remaining <= '0;
      code_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (pop) begin
        // same path from IDLE and at the end of a byte: no gap between bytes
        state     <= S_WAIT;
        code_q    <= head_sym;
        shreg     <= head_rest;
        remaining <= 2'd3;
        strobe_q  <= 1'b1;
      end else if (sym_next) begin
        code_q    <= sh_sym;
        shreg     <= sh_rest;
        remaining <= remaining - 2'd1;
        strobe_q  <= 1'b1;
      end else if (done_ok) begin
        state  <= S_IDLE;
        code_q <= 2'b00;
      end
    end
  end

  assign bus.tx_ready   = !full && !rst;
  assign bus.ppm_code   = code_q;
  assign bus.ppm_strobe = strobe_q;
  assign busy           = (state == S_WAIT) || !empty;
  assign fifo_count     = count;
endmodule

// File: tb/tb_ppm_symbol_feeder.sv
// Bench for ppm_symbol_feeder: an MSB-first and an LSB-first instance share stimulus;
// expected symbol streams are derived from the accepted byte list.
module tb_ppm_symbol_feeder;
  typedef logic [1:0] code_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ppm_done = 1'b0;
  logic       busy0, busy1;
  logic [2:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit last_acc = 1'b0;
  bit done_en = 1'b0;
  int done_dly = 1;
  int done_at = -1;

  logic [7:0] acc_q[$];
  int         acc_cyc[$];
  logic [1:0] obs0[$], obs1[$];
  int         strb_cyc[$], done_cyc[$];

  always #5 clk = ~clk;

  ppm_symbol_feeder_if if0 ();
  ppm_symbol_feeder_if if1 ();
  assign if0.tx_data  = tx_data;
  assign if0.tx_valid = tx_valid;
  assign if0.ppm_done = ppm_done;
  assign if1.tx_data  = tx_data;
  assign if1.tx_valid = tx_valid;
  assign if1.ppm_done = ppm_done;

  ppm_symbol_feeder #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0), .fifo_count(cnt0));
  ppm_symbol_feeder #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1), .fifo_count(cnt1));

  // Reference: every accepted byte contributes four 2-bit fields in the chosen order.
  function automatic code_q_t model_stream(bit msb);
    code_q_t q;
    foreach (acc_q[i])
      for (int k = 0; k < 4; k++)
        q.push_back(msb ? 2'(acc_q[i] >> (6 - 2*k)) : 2'(acc_q[i] >> (2*k)));
    return q;
  endfunction

  task automatic clear_model();
    acc_q.delete(); acc_cyc.delete();
    obs0.delete(); obs1.delete();
    strb_cyc.delete(); done_cyc.delete();
    done_at = -1;
  endtask

  // One clock: record acceptance, strobes, and play the modulator's done pulse.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = tx_valid && if0.tx_ready;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (acc) begin acc_q.push_back(tx_data); acc_cyc.push_back(cyc); end
    ppm_done = 1'b0;
    if (if0.ppm_strobe) begin
      obs0.push_back(if0.ppm_code);
      strb_cyc.push_back(cyc);
      if (done_en) done_at = cyc + done_dly;
    end
    if (if1.ppm_strobe) obs1.push_back(if1.ppm_code);
    if (done_en && cyc == done_at) begin ppm_done = 1'b1; done_cyc.push_back(cyc); end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    do begin tick(); n++; end while (!last_acc && n < 200);
    tx_valid = 1'b0;
    checks++;
    if (!last_acc) begin
      failures++;
      $display("FAIL push_timeout byte=%h got=not_accepted want=accepted", b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; ppm_done = 1'b0; done_en = 1'b0;
    tick(); tick();
    checks++;
    if ({if0.ppm_code, if0.ppm_strobe, if0.tx_ready, busy0, cnt0} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold_dut0 got=%b want=00000000",
               {if0.ppm_code, if0.ppm_strobe, if0.tx_ready, busy0, cnt0});
    end
    checks++;
    if ({if1.ppm_code, if1.ppm_strobe, if1.tx_ready, busy1, cnt1} !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold_dut1 got=%b want=00000000",
               {if1.ppm_code, if1.ppm_strobe, if1.tx_ready, busy1, cnt1});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({if0.tx_ready, if1.tx_ready, busy0, cnt0} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_release got=%b want=110000", {if0.tx_ready, if1.tx_ready, busy0, cnt0});
    end
    clear_model();
  endtask

  task automatic test_single();
    code_q_t got, exp;
    int ca;
    clear_model(); done_en = 1'b1; done_dly = 5;
    push(8'hB4);
    ca = cyc;
    checks++;
    if (cnt0 !== 3'd1) begin failures++; $display("FAIL single_count_accept got=%0d want=1", cnt0); end
    tick();
    checks++;
    if ({if0.ppm_strobe, cnt0} !== 4'b1000) begin
      failures++;
      $display("FAIL single_latency strobe=%b count=%0d want strobe=1 count=0", if0.ppm_strobe, cnt0);
    end
    repeat (40) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size()) begin
        failures++; $display("FAIL single_len dut%0d got=%0d want=%0d", d, got.size(), exp.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL single_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
    checks++;
    if (strb_cyc.size() < 1 || strb_cyc[0] - acc_cyc[0] != 1) begin
      failures++; $display("FAIL single_first_strobe got_strobes=%0d want first strobe 1 cycle after accept cycle %0d", strb_cyc.size(), ca);
    end
    for (int i = 1; i < strb_cyc.size(); i++) begin
      checks++;
      if (strb_cyc[i] - strb_cyc[i-1] != 6) begin
        failures++; $display("FAIL single_spacing idx=%0d got=%0d want=6", i, strb_cyc[i] - strb_cyc[i-1]);
      end
    end
    checks++;
    if ({busy0, busy1, if0.ppm_code, if1.ppm_code} !== 6'b000000) begin
      failures++; $display("FAIL single_idle got=%b want=000000", {busy0, busy1, if0.ppm_code, if1.ppm_code});
    end
  endtask

  task automatic test_back_to_back();
    code_q_t got, exp;
    clear_model(); done_en = 1'b1; done_dly = 1;
    push(8'h1B);
    push(8'hE4);
    repeat (30) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size() || exp.size() != 8) begin
        failures++; $display("FAIL b2b_len dut%0d got=%0d want=8", d, got.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL b2b_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
    checks++;
    if (strb_cyc.size() != 8 || done_cyc.size() < 7) begin
      failures++; $display("FAIL b2b_strobes got=%0d want=8", strb_cyc.size());
    end else
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (strb_cyc[i] - done_cyc[i-1] != 1) begin
          failures++; $display("FAIL b2b_gap idx=%0d got=%0d want=1", i, strb_cyc[i] - done_cyc[i-1]);
        end
      end
  endtask

  task automatic test_backpressure();
    code_q_t got, exp;
    int nb = 1;
    int n = 0;
    clear_model(); done_en = 1'b0;
    tx_data = 8'(nb); tx_valid = 1'b1;
    repeat (12) begin
      tick();
      if (last_acc && nb < 6) begin nb++; tx_data = 8'(nb); end
    end
    checks++;
    if (acc_q.size() != 5) begin failures++; $display("FAIL bp_accepted got=%0d want=5", acc_q.size()); end
    checks++;
    if ({if0.tx_ready, cnt0} !== 4'b0100) begin
      failures++; $display("FAIL bp_full ready=%b count=%0d want ready=0 count=4", if0.tx_ready, cnt0);
    end
    done_en = 1'b1; done_dly = 2; done_at = cyc + 1;
    do begin tick(); n++; end while (!last_acc && n < 100);
    tx_valid = 1'b0;
    checks++;
    if (acc_q.size() != 6 || acc_q[5] !== 8'h06) begin
      failures++; $display("FAIL bp_sixth_accept got=%0d bytes want=6", acc_q.size());
    end
    repeat (80) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size()) begin
        failures++; $display("FAIL bp_len dut%0d got=%0d want=%0d", d, got.size(), exp.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL bp_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
  endtask

  task automatic test_reset_mid();
    code_q_t got, exp;
    int n = 0;
    clear_model(); done_en = 1'b1; done_dly = 3;
    push(8'hFF);
    push(8'hAA);
    while (strb_cyc.size() < 2 && n < 50) begin tick(); n++; end
    checks++;
    if (strb_cyc.size() < 2) begin failures++; $display("FAIL rmid_timeout got=%0d strobes want=2", strb_cyc.size()); end
    rst = 1'b1;
    tick();
    checks++;
    if ({if0.ppm_code, if0.ppm_strobe, if0.tx_ready, busy0, cnt0,
         if1.ppm_code, if1.ppm_strobe, if1.tx_ready, busy1, cnt1} !== 16'h0000) begin
      failures++;
      $display("FAIL rmid_reset_values got=%b want=0", {if0.ppm_code, if0.ppm_strobe, if0.tx_ready, busy0, cnt0,
               if1.ppm_code, if1.ppm_strobe, if1.tx_ready, busy1, cnt1});
    end
    rst = 1'b0;
    clear_model();
    repeat (20) tick();
    checks++;
    if (obs0.size() + obs1.size() != 0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL rmid_quiet got=%0d strobes busy=%b want=0 strobes busy=0", obs0.size() + obs1.size(), busy0);
    end
    push(8'h00);
    repeat (30) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size() || exp.size() != 4) begin
        failures++; $display("FAIL rmid_len dut%0d got=%0d want=4", d, got.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL rmid_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
  endtask

  task automatic test_spurious();
    code_q_t got, exp;
    clear_model(); done_en = 1'b0;
    ppm_done = 1'b1;
    tick();
    tick();
    checks++;
    if ({if0.ppm_strobe, busy0, if0.ppm_code} !== 4'b0000 || obs0.size() != 0) begin
      failures++; $display("FAIL spur_idle strobe=%b busy=%b code=%0d want all 0", if0.ppm_strobe, busy0, if0.ppm_code);
    end
    push(8'h6C);
    tick();
    checks++;
    if (if0.ppm_strobe !== 1'b1) begin failures++; $display("FAIL spur_first_strobe got=%b want=1", if0.ppm_strobe); end
    ppm_done = 1'b1;
    repeat (6) tick();
    exp = model_stream(1'b1);
    checks++;
    if (strb_cyc.size() != 1 || if0.ppm_code !== exp[0] || busy0 !== 1'b1) begin
      failures++; $display("FAIL spur_strobe_done got=%0d strobes code=%0d want=1 strobe code=%0d", strb_cyc.size(), if0.ppm_code, exp[0]);
    end
    done_en = 1'b1; done_dly = 2; done_at = cyc + 1;
    repeat (30) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size() || exp.size() != 4) begin
        failures++; $display("FAIL spur_len dut%0d got=%0d want=4", d, got.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL spur_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
  endtask

  task automatic test_random();
    code_q_t got, exp;
    clear_model(); done_en = 1'b1;
    repeat (300) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      done_dly = $urandom_range(1, 5);
      tick();
      checks++;
      if (if0.tx_ready !== (cnt0 != 3'd4) || cnt0 > 3'd4) begin
        failures++; $display("FAIL rand_ready ready=%b count=%0d want ready=(count!=4)", if0.tx_ready, cnt0);
      end
    end
    tx_valid = 1'b0;
    repeat (150) tick();
    for (int d = 0; d < 2; d++) begin
      exp = model_stream(d == 0);
      if (d == 0) got = obs0; else got = obs1;
      checks++;
      if (got.size() != exp.size()) begin
        failures++; $display("FAIL rand_len dut%0d got=%0d want=%0d", d, got.size(), exp.size());
      end else
        foreach (exp[i]) begin
          checks++;
          if (got[i] !== exp[i]) begin
            failures++; $display("FAIL rand_code dut%0d idx=%0d got=%0d want=%0d", d, i, got[i], exp[i]);
          end
        end
    end
    checks++;
    if ({busy0, busy1, cnt0} !== 5'b00000) begin
      failures++; $display("FAIL rand_drained got=%b want=00000", {busy0, busy1, cnt0});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
